// File: rtl/usr_param_burst.sv
// Parametrised universal shift register with a burst sequencer that repeats a latched mode N times.
// Optional build macro USR_ROTATE_EN enables the rotate modes (100/101); without it they act as hold.
module usr_param_burst #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] in,
    input  logic             msb_in,
    input  logic             lsb_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] out,
    output logic             msb_out,
    output logic             lsb_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROTR  = 3'b100;
    localparam logic [2:0] MODE_ROTL  = 3'b101;
    localparam logic [2:0] MODE_ASHR  = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    state_t           state_r;
    logic [2:0]       lat_mode_r;
    logic [CNT_W-1:0] remaining_r;
    logic [WIDTH-1:0] out_r;
    logic             busy_r;
    logic             done_r;

    logic [2:0]       eff_mode_s;
    logic [WIDTH-1:0] next_val_s;

    // Next register value for one operation; serial fills come from the live pins.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] load_val,
        input logic             fill_msb,
        input logic             fill_lsb
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            MODE_HOLD:  res = cur;
            MODE_SHR:   res = {fill_msb, cur[WIDTH-1:1]};
            MODE_SHL:   res = {cur[WIDTH-2:0], fill_lsb};
            MODE_LOAD:  res = load_val;
`ifdef USR_ROTATE_EN
            MODE_ROTR:  res = {cur[0], cur[WIDTH-1:1]};
            MODE_ROTL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
`else
            MODE_ROTR:  res = cur;
            MODE_ROTL:  res = cur;
`endif
            MODE_ASHR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            MODE_CLEAR: res = '0;
            default:    res = cur;
        endcase
        return res;
    endfunction

    // Operation source: live mode while idle, latched mode while a burst runs.
    always_comb begin
        eff_mode_s = mode;
        if (state_r == ST_BURST) begin
            eff_mode_s = lat_mode_r;
        end else begin
            eff_mode_s = mode;
        end
        next_val_s = apply_op(eff_mode_s, out_r, in, msb_in, lsb_in);
    end

    // Burst sequencer and shift register state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            lat_mode_r  <= MODE_HOLD;
            remaining_r <= CNT_ZERO;
            out_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    if (start) begin
                        lat_mode_r <= mode;
                        if (count == CNT_ZERO) begin
                            // Empty burst: register holds, completion is still signalled.
                            done_r      <= 1'b1;
                            remaining_r <= CNT_ZERO;
                        end else if (count == CNT_ONE) begin
                            out_r       <= next_val_s;
                            done_r      <= 1'b1;
                            remaining_r <= CNT_ZERO;
                        end else begin
                            out_r       <= next_val_s;
                            remaining_r <= count - CNT_ONE;
                            busy_r      <= 1'b1;
                            state_r     <= ST_BURST;
                        end
                    end else begin
                        out_r <= next_val_s;
                    end
                end
                ST_BURST: begin
                    out_r <= next_val_s;
                    if (remaining_r == CNT_ONE) begin
                        remaining_r <= CNT_ZERO;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        remaining_r <= remaining_r - CNT_ONE;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    remaining_r <= CNT_ZERO;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign out     = out_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign msb_out = out_r[WIDTH-1];
    assign lsb_out = out_r[0];

endmodule
